alu_muldiv_decoder: RTL and testbench
=====================================

// Module: alu_muldiv_decoder
// PURPOSE
//  Extended ALU decode stage with an iterative RV32M multiply/divide sequencer.
//  - Decodes ALUOp/funct3/funct7 into base-ALU control and load/store type.
//  - Detects M-extension ops and runs them over multiple cycles.
//  - Sits in EX beside the base ALU; busy stalls the front of the pipeline.
// PARAMETERS
//  XLEN       32  operand/result width; must be even.
//  STEP_BITS  1   bits retired per CALC cycle (1, 2 or 4); must divide XLEN.
// PORTS
//  clk          in   1     clock, rising edge
//  rst_n        in   1     asynchronous active-low reset
//  alu_op       in   2     00 ld/st, 01 branch, 10 R/I-type ALU, 11 none
//  op5          in   1     opcode bit 5 (1 = R-type)
//  funct3       in   3     instruction funct3
//  funct7       in   7     instruction funct7
//  src_a        in   XLEN  rs1 value
//  src_b        in   XLEN  rs2 value
//  start        in   1     issue-valid for the instruction on the decode inputs
//  flush        in   1     synchronous abort of any in-flight M op
//  alu_ctrl     out  4     base-ALU control (combinational)
//  mem_type     out  3     load/store width/sign; 3'b111 when not ld/st
//  is_muldiv    out  1     decode inputs form an M op (combinational)
//  busy         out  1     sequencer not IDLE (registered)
//  done         out  1     one-cycle pulse: result valid
//  result       out  XLEN  M-op result; held until the next accepted op
// BEHAVIOUR
//  Decode (combinational):
//  - mem_type = 3'b111, except funct3 when alu_op = 00.
//  - alu_ctrl rules:
//    - 00 -> 0000.
//    - 01 -> {3'b001, funct3[1]} if funct3[2], else 0000.
//    - 10 -> {funct3[2] ? funct7[5] : funct7[5] & op5, funct3}.
//    - 11 -> 0000.
//  - is_muldiv = (alu_op == 10) && op5 && (funct7 == 7'b0000001).
//  - funct3 op map: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU,
//    100 DIV, 101 DIVU, 110 REM, 111 REMU.
//  Reset:
//  - rst_n low -> state IDLE, busy = 0, done = 0, result = 0, counter = 0.
//  - Asserting rst_n mid-operation discards the op.
//  Sequencer:
//  - FSM states: IDLE -> CALC -> DONE -> IDLE.
//  - Accept: start && is_muldiv && state == IDLE && !flush.
//    - Latches op, operand magnitudes and result sign.
//    - Normal op: state -> CALC, counter N = XLEN / STEP_BITS.
//    - Special case: state -> DONE directly, result latched; done in the next cycle.
//  - CALC: each edge retires STEP_BITS and decrements the counter.
//    - At counter 1 -> DONE, with the sign-fixed result registered.
//  - DONE: done = 1 for exactly one cycle, busy = 1; next edge -> IDLE.
//  - Latency: done is high N cycles after the accept edge (32 at the defaults).
//    Special cases: 1 cycle.
//  - start while busy: ignored; no queueing. Issue logic must hold the instruction.
//  - start with !is_muldiv: ignored; the base ALU handles the op.
//  - flush in any state: next edge -> IDLE, no done, result unchanged.
//    flush wins over a simultaneous accept.
//  - done && start in the same cycle (state DONE): not accepted; the earliest
//    back-to-back accept is the cycle after done.
//  Arithmetic:
//  - Multiply: unsigned shift-add on magnitudes into a 2*XLEN product,
//    two's-complement negated if the sign is set.
//    - MUL returns [XLEN-1:0]; MULH/MULHSU/MULHU return [2XLEN-1:XLEN].
//    - Signed operands: MULH both, MULHSU src_a only.
//  - Divide: restoring division on magnitudes.
//    - Quotient negated if the signs differ (DIV).
//    - Remainder takes the dividend's sign (REM).
//  - Special cases:
//    - Divide by zero: DIV/DIVU -> all ones; REM/REMU -> src_a.
//    - Signed overflow (src_a = 0x80..0, src_b = all ones): DIV -> src_a, REM -> 0.
// TESTING
//  - Decode: alu_op=10, op5=1, f3=000, f7=0100000 -> alu_ctrl=1000.
//    Same with op5=0 -> 0000. alu_op=00, f3=010 -> mem_type=010.
//  - MUL 7 * -3: start 1 cycle -> busy next cycle; done exactly 32 cycles after
//    the accept edge; result=0xFFFFFFEB.
//  - MULHU 0xFFFFFFFF * 0xFFFFFFFF -> 0xFFFFFFFE.
//    MULHSU 0xFFFFFFFF * 2 -> 0xFFFFFFFF.
//  - Special cases:
//    - DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000, done after 1 cycle.
//    - DIVU 5 / 0 -> 0xFFFFFFFF. REM -7 / 0 -> 0xFFFFFFF9.
//  - DIV -7 / 2 -> 0xFFFFFFFD. REM -7 / 2 -> 0xFFFFFFFF.
//    Repeat with STEP_BITS=4: same values, done at 8 cycles.
//  - flush at CALC cycle 10 -> busy low next cycle, no done, result unchanged.
//    rst_n low mid-CALC -> all outputs 0 immediately.

Source files
------------

// File: rtl/alu_muldiv_decoder.sv
// EX-stage decode for the base ALU plus an iterative RV32M multiply/divide unit.
// Shift-add multiply and restoring divide share one accumulator pair; results are sign-fixed at the end.
module alu_muldiv_decoder #(
   parameter int XLEN      = 32,
   parameter int STEP_BITS = 1
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [1:0]      alu_op_i,
   input  logic            op5_i,
   input  logic [2:0]      funct3_i,
   input  logic [6:0]      funct7_i,
   input  logic [XLEN-1:0] src_a_i,
   input  logic [XLEN-1:0] src_b_i,
   input  logic            start_i,
   input  logic            flush_i,
   output logic [3:0]      alu_ctrl_o,
   output logic [2:0]      mem_type_o,
   output logic            is_muldiv_o,
   output logic            busy_o,
   output logic            done_o,
   output logic [XLEN-1:0] result_o
);
   localparam int N  = XLEN / STEP_BITS;
   localparam int CW = $clog2(N + 1);
   localparam logic [CW-1:0]   CNT_INIT = CW'(N);
   localparam logic [XLEN-1:0] MIN_NEG  = {1'b1, {(XLEN-1){1'b0}}};

   typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

   state_t            state_q, state_d;
   logic [CW-1:0]     cnt_q;
   logic [2:0]        op_q;
   logic              neg_q;
   logic [XLEN-1:0]   opnd_q, acc_hi_q, acc_lo_q, result_q;

   always_comb begin
      alu_ctrl_o = 4'b0000;
      mem_type_o = 3'b111;
      case (alu_op_i)
         2'b00:   mem_type_o = funct3_i;
         2'b01:   if (funct3_i[2]) alu_ctrl_o = {3'b001, funct3_i[1]};
         2'b10:   alu_ctrl_o = {funct3_i[2] ? funct7_i[5] : (funct7_i[5] & op5_i), funct3_i};
         default: ;
      endcase
   end

   assign is_muldiv_o = (alu_op_i == 2'b10) && op5_i && (funct7_i == 7'b0000001);

   logic            is_div, a_sgn, b_sgn, a_neg, b_neg, res_neg, special;
   logic [XLEN-1:0] a_mag, b_mag, spec_res;

   always_comb begin
      is_div   = funct3_i[2];
      a_sgn    = is_div ? ~funct3_i[0] : (funct3_i[1:0] != 2'b11);
      b_sgn    = is_div ? ~funct3_i[0] : ~funct3_i[1];
      a_neg    = a_sgn & src_a_i[XLEN-1];
      b_neg    = b_sgn & src_b_i[XLEN-1];
      a_mag    = a_neg ? -src_a_i : src_a_i;
      b_mag    = b_neg ? -src_b_i : src_b_i;
      // Remainder follows the dividend; everything else follows the operand sign product.
      res_neg  = (is_div && funct3_i[1]) ? a_neg : (a_neg ^ b_neg);
      special  = 1'b0;
      spec_res = '0;
      if (is_div && (src_b_i == '0)) begin
         special  = 1'b1;
         spec_res = funct3_i[1] ? src_a_i : '1;
      end else if (is_div && a_sgn && (src_a_i == MIN_NEG) && (src_b_i == '1)) begin
         special  = 1'b1;
         spec_res = funct3_i[1] ? '0 : src_a_i;
      end
   end

   logic [XLEN-1:0] hi_nx, lo_nx;
   logic [XLEN:0]   sum, trial;

   always_comb begin
      hi_nx = acc_hi_q;
      lo_nx = acc_lo_q;
      sum   = '0;
      trial = '0;
      for (int i = 0; i < STEP_BITS; i++) begin
         if (op_q[2]) begin
            // hi holds the partial remainder, lo shifts the dividend out and quotient bits in.
            trial = {hi_nx, lo_nx[XLEN-1]};
            lo_nx = {lo_nx[XLEN-2:0], 1'b0};
            if (trial >= {1'b0, opnd_q}) begin
               trial    = trial - {1'b0, opnd_q};
               lo_nx[0] = 1'b1;
            end
            hi_nx = trial[XLEN-1:0];
         end else begin
            sum   = {1'b0, hi_nx} + (lo_nx[0] ? {1'b0, opnd_q} : '0);
            lo_nx = {sum[0], lo_nx[XLEN-1:1]};
            hi_nx = sum[XLEN:1];
         end
      end
   end

   logic [2*XLEN-1:0] prod;
   logic [XLEN-1:0]   quo_rem, fin_res;

   always_comb begin
      prod    = {hi_nx, lo_nx};
      if (neg_q) prod = -prod;
      quo_rem = op_q[1] ? hi_nx : lo_nx;
      if (neg_q) quo_rem = -quo_rem;
      if (op_q[2])                fin_res = quo_rem;
      else if (op_q[1:0] == 2'b00) fin_res = prod[XLEN-1:0];
      else                        fin_res = prod[2*XLEN-1:XLEN];
   end

   logic accept, last_step;
   assign accept    = start_i && is_muldiv_o && (state_q == S_IDLE) && !flush_i;
   assign last_step = (cnt_q == CW'(1));

   always_comb begin
      state_d = state_q;
      busy_o  = (state_q != S_IDLE);
      done_o  = (state_q == S_DONE);
      if (flush_i) state_d = S_IDLE;
      else begin
         case (state_q)
            S_IDLE:  if (accept) state_d = special ? S_DONE : S_CALC;
            S_CALC:  if (last_step) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= S_IDLE;
      else        state_q <= state_d;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q    <= '0;
         op_q     <= '0;
         neg_q    <= 1'b0;
         opnd_q   <= '0;
         acc_hi_q <= '0;
         acc_lo_q <= '0;
         result_q <= '0;
      end else if (accept) begin
         op_q     <= funct3_i;
         neg_q    <= res_neg;
         opnd_q   <= is_div ? b_mag : a_mag;
         acc_hi_q <= '0;
         acc_lo_q <= is_div ? a_mag : b_mag;
         cnt_q    <= special ? '0 : CNT_INIT;
         if (special) result_q <= spec_res;
      end else if ((state_q == S_CALC) && !flush_i) begin
         acc_hi_q <= hi_nx;
         acc_lo_q <= lo_nx;
         cnt_q    <= cnt_q - CW'(1);
         if (last_step) result_q <= fin_res;
      end
   end

   assign result_o = result_q;
endmodule

// File: tb/tb_alu_muldiv_decoder.sv
// Directed bench for alu_muldiv_decoder: a 1-bit/cycle and a 4-bit/cycle instance share all stimulus.
module tb_alu_muldiv_decoder;
   logic        clk = 1'b0, rst_n = 1'b0;
   logic [1:0]  alu_op = '0;
   logic        op5 = 1'b0;
   logic [2:0]  funct3 = '0;
   logic [6:0]  funct7 = '0;
   logic [31:0] src_a = '0, src_b = '0;
   logic        start = 1'b0, flush = 1'b0;
   logic [3:0]  ctrl1, ctrl4;
   logic [2:0]  mem1, mem4;
   logic        md1, md4, busy1, busy4, done1, done4;
   logic [31:0] res1, res4;
   int          n_vec = 0, n_err = 0;

   always #5 clk = ~clk;

   alu_muldiv_decoder #(.XLEN(32), .STEP_BITS(1)) dut1 (
      .clk(clk), .rst_n(rst_n), .alu_op_i(alu_op), .op5_i(op5), .funct3_i(funct3),
      .funct7_i(funct7), .src_a_i(src_a), .src_b_i(src_b), .start_i(start), .flush_i(flush),
      .alu_ctrl_o(ctrl1), .mem_type_o(mem1), .is_muldiv_o(md1), .busy_o(busy1),
      .done_o(done1), .result_o(res1));

   alu_muldiv_decoder #(.XLEN(32), .STEP_BITS(4)) dut4 (
      .clk(clk), .rst_n(rst_n), .alu_op_i(alu_op), .op5_i(op5), .funct3_i(funct3),
      .funct7_i(funct7), .src_a_i(src_a), .src_b_i(src_b), .start_i(start), .flush_i(flush),
      .alu_ctrl_o(ctrl4), .mem_type_o(mem4), .is_muldiv_o(md4), .busy_o(busy4),
      .done_o(done4), .result_o(res4));

   typedef struct {
      logic [1:0] op; logic op5; logic [2:0] f3; logic [6:0] f7;
      logic [3:0] ctrl; logic [2:0] mem; logic md;
   } dec_vec_t;

   typedef struct {
      logic [2:0] f3; logic [31:0] a; logic [31:0] b; logic [31:0] exp; bit spc;
   } ar_vec_t;

   dec_vec_t dv[11];
   ar_vec_t  av[17];

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
      end
   endtask

   // Present an M op for one cycle, then scramble the operands to prove they were latched.
   task automatic issue(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
      alu_op = 2'b10; op5 = 1'b1; funct7 = 7'b0000001; funct3 = f3;
      src_a = a; src_b = b; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0; src_a = ~a; src_b = b ^ 32'h5a5a_0001;
   endtask

   // e counts edges after the accept edge; e = 0 is the cycle right after it.
   task automatic run_op(input int idx, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp, input bit spc);
      int e1 = -1, e4 = -1;
      issue(f3, a, b);
      check($sformatf("op%0d busy after accept", idx), {31'b0, busy1}, 32'd1);
      for (int e = 0; e < 40 && (e1 < 0 || e4 < 0); e++) begin
         if (e > 0) begin @(posedge clk); #1; end
         if (done1 && e1 < 0) begin e1 = e; check($sformatf("op%0d result step1", idx), res1, exp); end
         if (done4 && e4 < 0) begin e4 = e; check($sformatf("op%0d result step4", idx), res4, exp); end
      end
      check($sformatf("op%0d latency step1", idx), e1, spc ? 0 : 32);
      check($sformatf("op%0d latency step4", idx), e4, spc ? 0 : 8);
      @(posedge clk); #1;
      check($sformatf("op%0d done/busy drop", idx), {28'b0, done1, busy1, done4, busy4}, 32'd0);
   endtask

   initial begin
      int e1;
      logic [31:0] held;

      dv[0]  = '{2'b10, 1'b1, 3'b000, 7'b0100000, 4'b1000, 3'b111, 1'b0};
      dv[1]  = '{2'b10, 1'b0, 3'b000, 7'b0100000, 4'b0000, 3'b111, 1'b0};
      dv[2]  = '{2'b00, 1'b0, 3'b010, 7'b0000000, 4'b0000, 3'b010, 1'b0};
      dv[3]  = '{2'b00, 1'b1, 3'b101, 7'b0000000, 4'b0000, 3'b101, 1'b0};
      dv[4]  = '{2'b01, 1'b0, 3'b100, 7'b0000000, 4'b0010, 3'b111, 1'b0};
      dv[5]  = '{2'b01, 1'b0, 3'b111, 7'b0000000, 4'b0011, 3'b111, 1'b0};
      dv[6]  = '{2'b01, 1'b0, 3'b001, 7'b0000000, 4'b0000, 3'b111, 1'b0};
      dv[7]  = '{2'b10, 1'b0, 3'b101, 7'b0100000, 4'b1101, 3'b111, 1'b0};
      dv[8]  = '{2'b10, 1'b1, 3'b000, 7'b0000001, 4'b0000, 3'b111, 1'b1};
      dv[9]  = '{2'b10, 1'b0, 3'b000, 7'b0000001, 4'b0000, 3'b111, 1'b0};
      dv[10] = '{2'b11, 1'b1, 3'b111, 7'b0000001, 4'b0000, 3'b111, 1'b0};

      av[0]  = '{3'b000, 32'd7,         32'hFFFFFFFD, 32'hFFFFFFEB, 1'b0}; // MUL 7*-3
      av[1]  = '{3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 1'b0}; // MULHU
      av[2]  = '{3'b010, 32'hFFFFFFFF, 32'd2,        32'hFFFFFFFF, 1'b0}; // MULHSU -1*2
      av[3]  = '{3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 1'b0}; // MULH -1*-1
      av[4]  = '{3'b001, 32'h80000000, 32'h80000000, 32'h40000000, 1'b0}; // MULH 2^62
      av[5]  = '{3'b000, 32'h12345678, 32'h10,       32'h23456780, 1'b0};
      av[6]  = '{3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1'b1}; // DIV overflow
      av[7]  = '{3'b110, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1'b1}; // REM overflow
      av[8]  = '{3'b101, 32'd5,         32'd0,        32'hFFFFFFFF, 1'b1}; // DIVU /0
      av[9]  = '{3'b110, 32'hFFFFFFF9, 32'd0,        32'hFFFFFFF9, 1'b1}; // REM -7/0
      av[10] = '{3'b100, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 1'b0}; // DIV -7/2
      av[11] = '{3'b110, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 1'b0}; // REM -7/2
      av[12] = '{3'b101, 32'd100,       32'd7,        32'd14,       1'b0};
      av[13] = '{3'b111, 32'd100,       32'd7,        32'd2,        1'b0};
      av[14] = '{3'b100, 32'd7,         32'hFFFFFFFE, 32'hFFFFFFFD, 1'b0}; // DIV 7/-2
      av[15] = '{3'b110, 32'd7,         32'hFFFFFFFE, 32'd1,        1'b0}; // REM 7/-2
      av[16] = '{3'b111, 32'hFFFFFFFF, 32'h80000000, 32'h7FFFFFFF, 1'b0};

      #1;
      check("reset outputs step1", {29'b0, busy1, done1, 1'b0} | res1, 32'd0);
      check("reset outputs step4", {29'b0, busy4, done4, 1'b0} | res4, 32'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;

      for (int i = 0; i < 11; i++) begin
         alu_op = dv[i].op; op5 = dv[i].op5; funct3 = dv[i].f3; funct7 = dv[i].f7;
         #1;
         check($sformatf("dec%0d alu_ctrl", i), {28'b0, ctrl1}, {28'b0, dv[i].ctrl});
         check($sformatf("dec%0d mem_type", i), {29'b0, mem1}, {29'b0, dv[i].mem});
         check($sformatf("dec%0d is_muldiv", i), {31'b0, md1}, {31'b0, dv[i].md});
         check($sformatf("dec%0d step4 alu_ctrl", i), {28'b0, ctrl4}, {28'b0, dv[i].ctrl});
      end
      @(posedge clk); #1;

      for (int i = 0; i < 17; i++) run_op(i, av[i].f3, av[i].a, av[i].b, av[i].exp, av[i].spc);

      // start while busy is ignored: the first op's result must come out on time
      issue(3'b000, 32'd7, 32'hFFFFFFFD);
      e1 = -1;
      for (int e = 0; e < 40 && e1 < 0; e++) begin
         if (e > 0) begin @(posedge clk); #1; end
         if (e == 5) begin
            funct3 = 3'b101; src_a = 32'd100; src_b = 32'd7; start = 1'b1;
         end else start = 1'b0;
         if (done1) e1 = e;
      end
      start = 1'b0;
      check("busy-start latency", e1, 32);
      check("busy-start result", res1, 32'hFFFFFFEB);
      @(posedge clk); #1;

      // flush mid-CALC: no done, result unchanged
      run_op(100, 3'b111, 32'd100, 32'd7, 32'd2, 1'b0);
      held = res1;
      issue(3'b000, 32'd7, 32'hFFFFFFFD);
      repeat (10) begin @(posedge clk); #1; end
      flush = 1'b1;
      @(posedge clk); #1;
      flush = 1'b0;
      check("flush busy", {31'b0, busy1}, 32'd0);
      e1 = -1;
      for (int e = 0; e < 40; e++) begin
         if (done1 && e1 < 0) e1 = e;
         @(posedge clk); #1;
      end
      check("flush no done", e1, -1);
      check("flush result held", res1, held);

      // flush beats a simultaneous accept
      funct3 = 3'b000; src_a = 32'd3; src_b = 32'd3; start = 1'b1; flush = 1'b1;
      @(posedge clk); #1;
      start = 1'b0; flush = 1'b0;
      check("flush+start busy", {30'b0, busy1, busy4}, 32'd0);

      // start held across done: DONE cycle does not accept, the next one does
      funct3 = 3'b101; src_a = 32'd5; src_b = 32'd0; start = 1'b1;
      @(posedge clk); #1;
      check("b2b first done", {30'b0, busy1, done1}, 32'd3);
      @(posedge clk); #1;
      check("b2b gap", {30'b0, busy1, done1}, 32'd0);
      @(posedge clk); #1;
      start = 1'b0;
      check("b2b second done", {30'b0, busy1, done1}, 32'd3);
      check("b2b result", res1, 32'hFFFFFFFF);
      @(posedge clk); #1;

      // reset mid-CALC clears everything immediately
      issue(3'b000, 32'd7, 32'hFFFFFFFD);
      repeat (5) begin @(posedge clk); #1; end
      rst_n = 1'b0;
      #1;
      check("async reset step1", {30'b0, busy1, done1} | res1, 32'd0);
      check("async reset step4", {30'b0, busy4, done4} | res4, 32'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      check("post-reset idle", {30'b0, busy1, done1}, 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
